// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared address map, peripheral select and read-FSM types for the data bus drivers
package bus_pkg;

    localparam logic [31:0] ADDR_RAM_BASE  = 32'h0000_1000;
    localparam logic [31:0] ADDR_TECLADO   = 32'h0000_2000;
    localparam logic [31:0] ADDR_LED       = 32'h0000_2008;
    localparam logic [31:0] ADDR_7SEG      = 32'h0000_200C;
    localparam logic [31:0] ADDR_TIMER     = 32'h0000_2010;
    localparam logic [31:0] ADDR_CTRL_UART = 32'h0000_2020;
    localparam logic [31:0] ADDR_DATA_UART = 32'h0000_2024;
    localparam logic [31:0] ADDR_CTRL_SPI  = 32'h0000_2100;

    localparam int unsigned RAM_WAIT_MIN = 1;
    localparam int unsigned RAM_WAIT_MAX = 4;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TECLADO,
        SEL_LED,
        SEL_7SEG,
        SEL_TIMER,
        SEL_CTRL_UART,
        SEL_DATA_UART,
        SEL_CTRL_SPI
    } bus_sel_t;

    typedef enum logic {
        IDLE,
        WAIT
    } rd_state_t;

    // RAM occupies the whole 4 KiB page whose upper 20 address bits match the base.
    function automatic logic is_ram_addr(input logic [31:0] addr);
        return addr[31:12] == ADDR_RAM_BASE[31:12];
    endfunction

endpackage

// File: rtl/bus_decoder.sv
// rtl/bus_decoder.sv - combinational address to peripheral select, shared by the read and write drivers
module bus_decoder
    import bus_pkg::*;
(
    input  logic [31:0] address_i,
    output bus_sel_t    sel_o
);

    always_comb begin
        sel_o = SEL_NONE;
        if (is_ram_addr(address_i)) begin
            sel_o = SEL_RAM;
        end else begin
            case (address_i)
                ADDR_TECLADO:   sel_o = SEL_TECLADO;
                ADDR_LED:       sel_o = SEL_LED;
                ADDR_7SEG:      sel_o = SEL_7SEG;
                ADDR_TIMER:     sel_o = SEL_TIMER;
                ADDR_CTRL_UART: sel_o = SEL_CTRL_UART;
                ADDR_DATA_UART: sel_o = SEL_DATA_UART;
                ADDR_CTRL_SPI:  sel_o = SEL_CTRL_SPI;
                default:        sel_o = SEL_NONE;
            endcase
        end
    end

endmodule

// File: rtl/bus_driver_lectura.sv
// rtl/bus_driver_lectura.sv - read-side bus controller: decode, RAM wait states, registered data and strobes
// Optional macro BUS_READ_ERR_EN: enables err_o and treats misaligned RAM reads as errors.
module bus_driver_lectura
    import bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT     = 1,
    parameter logic [31:0] DEFAULT_DATA = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] address_i,
    input  logic        re_i,
    input  logic [31:0] do_ram_i,
    input  logic [31:0] do_teclado_i,
    input  logic [31:0] do_led_i,
    input  logic [31:0] do_7seg_i,
    input  logic [31:0] do_timer_i,
    input  logic [31:0] do_ctrl_uart_i,
    input  logic [31:0] do_data_uart_i,
    input  logic [31:0] do_ctrl_spi_i,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        re_ram_o,
    output logic        re_data_uart_o,
    output logic        re_teclado_o,
    output logic        err_o
);

    generate
        if (RAM_WAIT < RAM_WAIT_MIN || RAM_WAIT > RAM_WAIT_MAX) begin : g_bad_ram_wait
            $error("bus_driver_lectura: RAM_WAIT must lie in 1..4");
        end
    endgenerate

    localparam logic [2:0] L_RAM_WAIT = 3'(RAM_WAIT);

    rd_state_t   r_state;
    rd_state_t   w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic [31:0] r_rdata;
    logic [31:0] w_rdata_next;
    logic        r_valid;
    logic        w_valid_next;
    logic        r_re_data_uart;
    logic        w_re_data_uart_next;
    logic        r_re_teclado;
    logic        w_re_teclado_next;
    logic        w_err_next;

    bus_sel_t    w_sel;
    bus_sel_t    w_sel_eff;
    logic [31:0] w_reg_data;
    logic        w_accept;

    bus_decoder u_bus_decoder (
        .address_i (address_i),
        .sel_o     (w_sel)
    );

`ifdef BUS_READ_ERR_EN
    // A misaligned RAM access is demoted to an unmapped read: no wait states, error pulse.
    assign w_sel_eff = (w_sel == SEL_RAM && address_i[1:0] != 2'b00) ? SEL_NONE : w_sel;
`else
    assign w_sel_eff = w_sel;
`endif

    assign w_accept = (r_state == IDLE) && re_i;

    always_comb begin
        w_reg_data = DEFAULT_DATA;
        case (w_sel_eff)
            SEL_TECLADO:   w_reg_data = do_teclado_i;
            SEL_LED:       w_reg_data = do_led_i;
            SEL_7SEG:      w_reg_data = do_7seg_i;
            SEL_TIMER:     w_reg_data = do_timer_i;
            SEL_CTRL_UART: w_reg_data = do_ctrl_uart_i;
            SEL_DATA_UART: w_reg_data = do_data_uart_i;
            SEL_CTRL_SPI:  w_reg_data = do_ctrl_spi_i;
            default:       w_reg_data = DEFAULT_DATA;
        endcase
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_rdata_next        = r_rdata;
        w_valid_next        = 1'b0;
        w_re_data_uart_next = 1'b0;
        w_re_teclado_next   = 1'b0;
        w_err_next          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_sel_eff == SEL_RAM) begin
                        w_state_next = WAIT;
                        w_cnt_next   = L_RAM_WAIT;
                    end else begin
                        w_rdata_next        = w_reg_data;
                        w_valid_next        = 1'b1;
                        w_re_data_uart_next = (w_sel_eff == SEL_DATA_UART);
                        w_re_teclado_next   = (w_sel_eff == SEL_TECLADO);
                        w_err_next          = (w_sel_eff == SEL_NONE);
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_rdata_next = do_ram_i;
                    w_valid_next = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_cnt          <= 3'd0;
            r_rdata        <= 32'h0;
            r_valid        <= 1'b0;
            r_re_data_uart <= 1'b0;
            r_re_teclado   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_rdata        <= w_rdata_next;
            r_valid        <= w_valid_next;
            r_re_data_uart <= w_re_data_uart_next;
            r_re_teclado   <= w_re_teclado_next;
        end
    end

`ifdef BUS_READ_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign err_o = r_err;
`else
    logic w_err_unused;
    assign w_err_unused = w_err_next;
    assign err_o        = 1'b0;
`endif

    assign rdata_o        = r_rdata;
    assign valid_o        = r_valid;
    assign busy_o         = (r_state == WAIT);
    assign re_ram_o       = (r_state == WAIT);
    assign re_data_uart_o = r_re_data_uart;
    assign re_teclado_o   = r_re_teclado;

endmodule

// File: tb/tb_bus_driver_lectura.sv
// tb/tb_bus_driver_lectura.sv - self-checking bench for bus_driver_lectura against a table-driven read model
module tb_bus_driver_lectura;

    localparam int          RW  = 2;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic        re;
    logic [31:0] pd [8];
    logic [31:0] rdata;
    logic        valid, busy, re_ram, re_duart, re_tecl, err;

    int          n_assert;
    int          n_fail;
    logic [31:0] last_rdata;
    logic [31:0] reg_addr [8];

    bus_driver_lectura #(
        .RAM_WAIT     (RW),
        .DEFAULT_DATA (DEF)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .address_i      (address),
        .re_i           (re),
        .do_ram_i       (pd[0]),
        .do_teclado_i   (pd[1]),
        .do_led_i       (pd[2]),
        .do_7seg_i      (pd[3]),
        .do_timer_i     (pd[4]),
        .do_ctrl_uart_i (pd[5]),
        .do_data_uart_i (pd[6]),
        .do_ctrl_spi_i  (pd[7]),
        .rdata_o        (rdata),
        .valid_o        (valid),
        .busy_o         (busy),
        .re_ram_o       (re_ram),
        .re_data_uart_o (re_duart),
        .re_teclado_o   (re_tecl),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: -1 unmapped, 0 RAM, 1..7 register index into reg_addr / pd.
    function automatic int kind_of(input logic [31:0] a);
        for (int i = 1; i < 8; i++)
            if (a == reg_addr[i]) return i;
        if ((a >> 12) == 32'd1) begin
`ifdef BUS_READ_ERR_EN
            if ((a % 4) != 0) return -1;
`endif
            return 0;
        end
        return -1;
    endfunction

    function automatic logic exp_err(input int k);
`ifdef BUS_READ_ERR_EN
        return k < 0;
`else
        return (k < 0) && 1'b0;
`endif
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " valid"}, valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " re_ram"}, re_ram, 0);
        chk({tag, " re_duart"}, re_duart, 0);
        chk({tag, " re_tecl"}, re_tecl, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " rdata held"}, rdata, last_rdata);
    endtask

    // Issues one read (re left high on return) and checks its full timeline.
    task automatic do_read(input logic [31:0] addr, input bit swap_ram);
        int          k;
        logic [31:0] exp_d;
        string       t;
        k       = kind_of(addr);
        t       = $sformatf("rd@%h", addr);
        re      = 1'b1;
        address = addr;
        if (k == 0) begin
            for (int w = 1; w <= RW; w++) begin
                tick();
                chk({t, " busy"}, busy, 1);
                chk({t, " re_ram"}, re_ram, 1);
                chk({t, " wait valid"}, valid, 0);
            end
            if (swap_ram) pd[0] = $urandom;
            exp_d = pd[0];
            tick();
            chk({t, " ram valid"}, valid, 1);
            chk({t, " ram rdata"}, rdata, exp_d);
            chk({t, " ram busy"}, busy, 0);
            chk({t, " ram err"}, err, 0);
        end else begin
            exp_d = (k < 0) ? DEF : pd[k];
            tick();
            chk({t, " valid"}, valid, 1);
            chk({t, " rdata"}, rdata, exp_d);
            chk({t, " busy"}, busy, 0);
            chk({t, " re_duart"}, re_duart, (k == 6));
            chk({t, " re_tecl"}, re_tecl, (k == 1));
            chk({t, " err"}, err, exp_err(k));
        end
        last_rdata = exp_d;
    endtask

    task automatic idle(input string tag);
        re = 1'b0;
        tick();
        chk_quiet(tag);
    endtask

    initial begin
        logic [31:0] a;
        n_assert   = 0;
        n_fail     = 0;
        last_rdata = 32'h0;
        reg_addr   = '{32'h0, 32'h2000, 32'h2008, 32'h200C, 32'h2010, 32'h2020, 32'h2024, 32'h2100};
        for (int i = 0; i < 8; i++) pd[i] = 32'h0;
        rst     = 1'b1;
        re      = 1'b0;
        address = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset rdata", rdata, 0);
        chk_quiet("reset");

        pd[2] = 32'hA5;
        do_read(32'h2008, 1'b0);
        idle("after led");

        pd[0] = 32'hCAFE_0001;
        do_read(32'h1004, 1'b0);
        idle("after ram");

        pd[6] = 32'h1234_5678;
        do_read(32'h2024, 1'b0);
        idle("after uart single pulse");

        pd[4] = 32'h0000_7777;
        pd[7] = 32'h5151_0000;
        do_read(32'h2010, 1'b0);
        do_read(32'h2100, 1'b0);
        idle("after back to back");

        do_read(32'h3000, 1'b0);
        do_read(32'h0000_0000, 1'b0);
        pd[1] = 32'h0000_00AB;
        do_read(32'h2000, 1'b0);
        do_read(32'h2001, 1'b0);
        do_read(32'h1FFC, 1'b1);
        do_read(32'h1001, 1'b1);
        do_read(32'h0FFF, 1'b0);
        do_read(32'h1000_2008, 1'b0);
        idle("after boundaries");

        re      = 1'b1;
        address = 32'h1004;
        tick();
        chk("rst-in-wait busy", busy, 1);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        re         = 1'b0;
        last_rdata = 32'h0;
        chk_quiet("rst-in-wait");
        tick();
        chk_quiet("rst-in-wait+1");

        pd[2] = 32'h0BAD_F00D;
        do_read(32'h2008, 1'b0);
        re      = 1'b1;
        address = 32'h2008;
        rst     = 1'b1;
        tick();
        rst        = 1'b0;
        re         = 1'b0;
        last_rdata = 32'h0;
        chk_quiet("rst+re");

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 8; i++) pd[i] = $urandom;
            case ($urandom_range(0, 3))
                0:       a = reg_addr[$urandom_range(1, 7)];
                1:       a = 32'h1000 | 32'($urandom_range(0, 4095));
                2:       a = $urandom;
                default: a = 32'h2000 + 32'(4 * $urandom_range(0, 70));
            endcase
            do_read(a, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) idle("rand idle");
        end
        idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_driver_lectura.md
# bus_driver_lectura

Read-side bus controller between the RISC-V core's data port and the memory-mapped peripherals: RAM, keyboard, LEDs, 7-segment display, timer, UART and SPI. It decodes each read address and selects the matching peripheral's data. It inserts wait states for the synchronous RAM, returns registered read data with a one-cycle valid pulse, and issues read-side-effect strobes (UART RX pop, keyboard clear). It is the read counterpart of the write-enable bus driver and uses the same address map.

## Interface
- `RAM_WAIT`, default 1: RAM read latency in cycles, legal range 1–4.
- `DEFAULT_DATA`, default 32'h0000_0000: data returned for unmapped reads.

- `clk_i` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous, active-high reset.
- `address_i` in 32: read address, valid while `re_i` is high.
- `re_i` in 1: read request, sampled only in IDLE.
- `do_ram_i`, `do_teclado_i`, `do_led_i`, `do_7seg_i`, `do_timer_i`, `do_ctrl_uart_i`, `do_data_uart_i`, `do_ctrl_spi_i` in 32 each: peripheral read data.
- `rdata_o` out 32: registered read data.
- `valid_o` out 1: one-cycle pulse, `rdata_o` valid.
- `busy_o` out 1: stall to the core, high while in WAIT.
- `re_ram_o` out 1: RAM read enable, high during WAIT.
- `re_data_uart_o` out 1: UART RX pop strobe.
- `re_teclado_o` out 1: keyboard clear strobe.
- `err_o` out 1: unmapped-read pulse (see Configuration).

## Operation
- Address decode:
  - RAM: `address_i[31:12]==20'h1`.
  - Exact matches: teclado `'h2000`, led `'h2008`, 7seg `'h200C`, timer `'h2010`, ctrl_uart `'h2020`, data_uart `'h2024`, ctrl_spi `'h2100`.
  - Everything else is unmapped, including `'h0`.
- FSM states: IDLE, WAIT. A 3-bit counter `cnt` tracks WAIT cycles.
- IDLE, `re_i`=1, register hit: `rdata_o` ← selected `do_*_i`; `valid_o`←1; stay in IDLE.
- IDLE, `re_i`=1, RAM hit: `cnt`←`RAM_WAIT`; go to WAIT; `valid_o`←0.
- IDLE, `re_i`=1, unmapped: `rdata_o`←`DEFAULT_DATA`; `valid_o`←1; stay in IDLE.
- IDLE, `re_i`=0: `valid_o`←0.
- WAIT: `cnt` decrements every cycle. At the edge where `cnt`==1: `rdata_o`←`do_ram_i`, `valid_o`←1, go to IDLE.
- `re_i` is ignored in WAIT. The core must hold its request while `busy_o` is high; no request is queued.
- `re_data_uart_o` pulses for exactly one cycle per accepted data_uart read. A held `re_i` over N register-read cycles counts as N reads, so the core must deassert `re_i` after `valid_o`.
- `re_teclado_o` behaves the same way for teclado reads.
- `rdata_o` holds its last value between valid pulses.
- Width rules:
  - `cnt` is 3 bits.
  - A `RAM_WAIT` outside 1–4 is rejected by an elaboration-time assertion.
  - Address comparisons use the full 32 bits.

## Timing
- Reset values: state IDLE, `cnt`=0, `rdata_o`=32'h0, and `valid_o`, `busy_o`, `re_ram_o`, `re_data_uart_o`, `re_teclado_o`, `err_o` all 0.
- Register or unmapped read accepted in cycle N: `valid_o` and `rdata_o` in cycle N+1. Back-to-back reads give one result per cycle.
- RAM read accepted in cycle N:
  - `busy_o` and `re_ram_o` high in cycles N+1 … N+`RAM_WAIT`.
  - `valid_o` high in cycle N+`RAM_WAIT`+1.
  - The next request is accepted in cycle N+`RAM_WAIT`+1.
- Strobes `re_data_uart_o` and `re_teclado_o` are registered: high in cycle N+1, coincident with `valid_o`.
- Reset during WAIT: return to IDLE next cycle, no `valid_o`, RAM result discarded.
- `rst_i` and `re_i` high in the same cycle: reset wins, and the request is dropped.

## Configuration
- `BUS_READ_ERR_EN` defined:
  - An unmapped read pulses `err_o` in cycle N+1, together with `valid_o`.
  - A RAM address with `address_i[1:0]`≠0 is also treated as an error: `DEFAULT_DATA` is returned, `err_o` pulses, and there is no WAIT.
- `BUS_READ_ERR_EN` undefined:
  - `err_o` is tied to 0.
  - Misaligned RAM addresses are read normally.

## Structure
- Package `bus_pkg` holds:
  - address constants `ADDR_RAM_BASE`, `ADDR_TECLADO`, `ADDR_LED`, `ADDR_7SEG`, `ADDR_TIMER`, `ADDR_CTRL_UART`, `ADDR_DATA_UART`, `ADDR_CTRL_SPI`;
  - enum `bus_sel_t` with values SEL_NONE, SEL_RAM, SEL_TECLADO, SEL_LED, SEL_7SEG, SEL_TIMER, SEL_CTRL_UART, SEL_DATA_UART, SEL_CTRL_SPI;
  - enum `rd_state_t` with values IDLE, WAIT.
- The write driver migrates to the same constants.
- Sub-module `bus_decoder`: combinational `address_i` → `bus_sel_t`. It is shared with the write driver.

## Test plan
- Reset, then LED read: `re_i`=1, `address_i`=`'h2008`, `do_led_i`=32'hA5 → cycle N+1 has `valid_o`=1 and `rdata_o`=32'hA5, `busy_o`=0.
- RAM read with `RAM_WAIT`=2: `address_i`=`'h1004`, `do_ram_i`=32'hCAFE_0001 → `busy_o`/`re_ram_o` high in N+1 and N+2; `valid_o` and `rdata_o`=32'hCAFE_0001 in N+3.
- UART data read: `address_i`=`'h2024` for one cycle → `re_data_uart_o` is a single pulse in N+1 and `rdata_o`=`do_data_uart_i`.
- Back-to-back reads: timer (`'h2010`) then ctrl_spi (`'h2100`) → valid in N+1 and N+2 with the matching data.
- Unmapped `'h3000` with `BUS_READ_ERR_EN` → `rdata_o`=`DEFAULT_DATA`, `valid_o`=1, `err_o`=1. Same stimulus without the macro → `err_o`=0.
- `rst_i` asserted in the first WAIT cycle of a RAM read → no `valid_o`; all outputs at their reset values in the next cycle.
